// File: rtl/hack_pkg.sv
// Shared Hack CPU types: address type, jump encodings, reset vector.
// Halt FSM state encoding lives here too so tools can share it.
package hack_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [2:0] {
    JNULL = 3'b000,
    JGT   = 3'b001,
    JEQ   = 3'b010,
    JGE   = 3'b011,
    JLT   = 3'b100,
    JNE   = 3'b101,
    JLE   = 3'b110,
    JMP   = 3'b111
  } jump_e;

  typedef enum logic {
    RUN,
    HALT
  } halt_e;

  localparam addr_t HACK_RESET_VEC = 16'h0000;

endpackage

// File: rtl/hack_jump_cond.sv
// Hack C-instruction jump condition: (jbits, zr, ng, is_c) -> take.
// Purely combinational; zr wins over ng when both are set.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jbits,
  input  logic       zr,
  input  logic       ng,
  input  logic       is_c,
  output logic       take
);

  logic lt;
  logic eq;
  logic gt;
  logic hit;

  always_comb begin
    eq  = zr;
    lt  = ng & ~zr;
    gt  = ~zr & ~ng;
    hit = 1'b0;
    unique case (jump_e'(jbits))
      JNULL:   hit = 1'b0;
      JGT:     hit = gt;
      JEQ:     hit = eq;
      JGE:     hit = gt | eq;
      JLT:     hit = lt;
      JNE:     hit = ~eq;
      JLE:     hit = lt | eq;
      JMP:     hit = 1'b1;
      default: hit = 1'b0;
    endcase
    take = is_c & hit;
  end

endmodule

// File: rtl/hack_pc.sv
// Hack program counter with jump evaluation and end-of-program halt flag.
// Optional trace outputs (jump_count, last_src) under HACK_PC_TRACE_EN.
module hack_pc
  import hack_pkg::*;
#(
  parameter int                WIDTH     = $bits(addr_t),
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(HACK_RESET_VEC),
  parameter int                HALT_CNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             is_c_instr,
  input  logic [2:0]       jbits,
  input  logic             alu_zr,
  input  logic             alu_ng,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             jump_taken,
  output logic             halted
`ifdef HACK_PC_TRACE_EN
  ,
  output logic [31:0]      jump_count,
  output logic [WIDTH-1:0] last_src
`endif
);

  localparam int CW = $clog2(HALT_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HALT_CNT);

  logic          take;
  logic          loop_hit;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  halt_e         state_q;
  halt_e         state_d;

  hack_jump_cond u_cond (
    .jbits (jbits),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .is_c  (is_c_instr),
    .take  (take)
  );

  // A jump back onto itself, or onto the @END just before it.
  assign loop_hit = take
                  & (jump_e'(jbits) == JMP)
                  & ((target == pc)
                   | (target == pc - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VEC;
      jump_taken <= 1'b0;
    end else if (en) begin
      pc         <= take ? target : pc + WIDTH'(1);
      jump_taken <= take;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    if (en) begin
      unique case (state_q)
        RUN: begin
          if (loop_hit) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) state_d = HALT;
          end else begin
            cnt_d = '0;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  assign halted = (state_q == HALT);

`ifdef HACK_PC_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_count <= '0;
      last_src   <= '0;
    end else if (en && take) begin
      jump_count <= jump_count + 32'd1;
      last_src   <= pc;
    end
  end
`endif

endmodule

// File: tb/tb_hack_pc.sv
// Directed, table-driven bench for hack_pc.
module tb_hack_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        is_c_instr;
  logic [2:0]  jbits;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] target;
  logic [15:0] pc;
  logic        jump_taken;
  logic        halted;
`ifdef HACK_PC_TRACE_EN
  logic [31:0] jump_count;
  logic [15:0] last_src;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       is_c;
    logic [2:0] jb;
    logic       zr;
    logic       ng;
    logic       take;
  } vec_t;

  vec_t tbl[30];
  logic [15:0] exp_pc;

  hack_pc #(
    .WIDTH     (16),
    .RESET_VEC (16'h0000),
    .HALT_CNT  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .is_c_instr (is_c_instr),
    .jbits      (jbits),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .target     (target),
    .pc         (pc),
    .jump_taken (jump_taken),
    .halted     (halted)
`ifdef HACK_PC_TRACE_EN
    ,
    .jump_count (jump_count),
    .last_src   (last_src)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic c, input logic [2:0] j,
                       input logic z, input logic n,
                       input logic [15:0] t);
    is_c_instr = c;
    jbits      = j;
    alu_zr     = z;
    alu_ng     = n;
    target     = t;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 3'b010, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'b011, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 3'b100, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 3'b101, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 3'b101, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 3'b110, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 3'b110, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 3'b110, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b1};
    tbl[22] = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b1};
    tbl[23] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1};
    tbl[24] = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 3'b011, 1'b1, 1'b0, 1'b0};
    tbl[27] = '{1'b1, 3'b010, 1'b1, 1'b1, 1'b1};
    tbl[28] = '{1'b1, 3'b100, 1'b1, 1'b1, 1'b0};
    tbl[29] = '{1'b1, 3'b001, 1'b1, 1'b1, 1'b0};

    // 1: reset overrides an enabled, always-jump cycle
    rst = 1'b1;
    en  = 1'b1;
    drive(1'b1, 3'b111, 1'b0, 1'b0, 16'h1234);
    step();
    step();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_jt", 32'(jump_taken), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
`ifdef HACK_PC_TRACE_EN
    check("rst_jcnt", jump_count, 32'h0);
    check("rst_src", 32'(last_src), 32'h0);
`endif

    // 2: plain increment, then a stall
    rst = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("inc_pc%0d", i), 32'(pc), 32'(i));
    end
    en = 1'b0;
    step();
    check("stall_pc", 32'(pc), 32'h5);
    en = 1'b1;

    // 3: jump condition sweep
    exp_pc = 16'h0005;
    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].is_c, tbl[i].jb, tbl[i].zr, tbl[i].ng,
            16'h0100);
      step();
      exp_pc = tbl[i].take ? 16'h0100 : exp_pc + 16'h1;
      check($sformatf("sweep_pc%0d", i), 32'(pc), 32'(exp_pc));
      check($sformatf("sweep_jt%0d", i), 32'(jump_taken),
            32'(tbl[i].take));
    end

    // stall holds jump_taken high after a taken jump
    drive(1'b1, 3'b111, 1'b0, 1'b0, 16'h0200);
    step();
    check("jmp_pc", 32'(pc), 32'h0200);
    en = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    step();
    check("hold_jt", 32'(jump_taken), 32'h1);
    check("hold_pc", 32'(pc), 32'h0200);
    en = 1'b1;

    // 4: pc=0 against target 0xFFFF counts, then FFFF wraps
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 3'b111, 1'b0, 1'b0, 16'hFFFF);
    step();
    check("wrap_jmp_pc", 32'(pc), 32'hFFFF);
    step();
    step();
    check("wrap_halt3", 32'(halted), 32'h0);
    step();
    check("wrap_halt4", 32'(halted), 32'h1);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    step();
    check("wrap_pc", 32'(pc), 32'h0000);
    check("sticky", 32'(halted), 32'h1);

    // 5: @0x0010 / 0;JMP at 0x0011 loop reaches halt
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_halted", 32'(halted), 32'h0);
    drive(1'b1, 3'b111, 1'b0, 1'b0, 16'h0011);
    step();
    check("to11_pc", 32'(pc), 32'h0011);
    target = 16'h0010;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("loop_pc%0d", i), 32'(pc), 32'h0010);
      check($sformatf("loop_halt%0d", i), 32'(halted),
            32'(i == 4));
    end
`ifdef HACK_PC_TRACE_EN
    check("trace_cnt", jump_count, 32'd5);
    check("trace_src", 32'(last_src), 32'h0010);
`endif

    // 6: reset mid-loop clears everything
    rst = 1'b1;
    step();
    check("rst3_pc", 32'(pc), 32'h0);
    check("rst3_halted", 32'(halted), 32'h0);
    check("rst3_jt", 32'(jump_taken), 32'h0);
`ifdef HACK_PC_TRACE_EN
    check("rst3_jcnt", jump_count, 32'h0);
    check("rst3_src", 32'(last_src), 32'h0);
`endif

    // 5b: loop broken after 3 jumps never halts
    rst = 1'b0;
    target = 16'h0011;
    step();
    target = 16'h0010;
    step();
    step();
    step();
    check("brk_halt3", 32'(halted), 32'h0);
    target = 16'h0020;
    step();
    check("brk_pc", 32'(pc), 32'h0020);
    step();
    check("brk_halt", 32'(halted), 32'h0);
    check("brk_pc2", 32'(pc), 32'h0020);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
